// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state type for the dual-mode MAC tile
package mac_pkg;
  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_FLUSH = 2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } state_t;
endpackage

// File: rtl/mac.sv
// rtl/mac.sv - unsigned(a) * signed(b) + c; MAC_SAT_EN selects a saturating add instead of wrap
module mac #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic [bw-1:0]      i_a,
  input  logic [bw-1:0]      i_b,
  input  logic [psum_bw-1:0] i_c,
  output logic [psum_bw-1:0] o_out
);
  logic signed [psum_bw-1:0] w_a_ext;
  logic signed [psum_bw-1:0] w_b_ext;
  logic signed [psum_bw-1:0] w_prod;

  assign w_a_ext = $signed({{(psum_bw-bw){1'b0}}, i_a});
  assign w_b_ext = $signed({{(psum_bw-bw){i_b[bw-1]}}, i_b});
  assign w_prod  = w_a_ext * w_b_ext;

`ifdef MAC_SAT_EN
  logic [psum_bw:0] w_sum;

  assign w_sum = {i_c[psum_bw-1], i_c} + {w_prod[psum_bw-1], w_prod};

  // Overflow shows as disagreement between the guard bit and the result sign.
  always_comb begin
    o_out = w_sum[psum_bw-1:0];
    if (w_sum[psum_bw] != w_sum[psum_bw-1]) begin
      o_out = w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end
  end
`else
  assign o_out = i_c + w_prod;
`endif
endmodule

// File: rtl/mac_tile_dm.sv
// rtl/mac_tile_dm.sv - dual-mode (WS/OS) systolic PE tile; MAC_SAT_EN enables saturating adds
module mac_tile_dm
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  input  logic [2:0]         inst_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [bw-1:0]      out_e,
  output logic [2:0]         inst_e,
  output logic [psum_bw-1:0] out_s
);
  logic [bw-1:0]      r_a_q;
  logic [bw-1:0]      r_b_q;
  logic [psum_bw-1:0] r_c_q;
  logic [psum_bw-1:0] r_acc_q;
  logic [2:0]         r_inst_q;
  logic               r_mode_q;
  state_t             r_state;

  state_t             w_state_nxt;
  logic               w_mode_chg;
  logic               w_ws;
  logic               w_capture;
  logic               w_inst0_nxt;
  logic [psum_bw-1:0] w_mac_c;
  logic [psum_bw-1:0] w_mac;
  logic [psum_bw-1:0] w_b_ext;

  assign w_mode_chg = (mode != r_mode_q);
  assign w_ws       = (r_mode_q == MODE_WS);

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  // A flush in the same cycle as a load re-arms first, so the load still captures.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg || !w_ws) begin
      w_state_nxt = EMPTY;
    end else begin
      if (inst_w[INST_FLUSH]) w_state_nxt = EMPTY;
      if (inst_w[INST_LOAD] && (inst_w[INST_FLUSH] || r_state == EMPTY)) w_state_nxt = LOADED;
    end
  end

  always_comb begin
    w_capture   = w_ws && !w_mode_chg && inst_w[INST_LOAD]
                  && (inst_w[INST_FLUSH] || r_state == EMPTY);
    w_inst0_nxt = inst_w[INST_LOAD] && !w_capture;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_q    <= '0;
      r_b_q    <= '0;
      r_c_q    <= '0;
      r_acc_q  <= '0;
      r_inst_q <= 3'b000;
      r_mode_q <= MODE_WS;
    end else begin
      r_mode_q <= mode;
      r_inst_q <= {inst_w[INST_FLUSH], inst_w[INST_EXEC], w_inst0_nxt};
      if (inst_w[INST_EXEC] || inst_w[INST_LOAD]) r_a_q <= in_w;
      if (w_mode_chg) begin
        r_b_q   <= '0;
        r_c_q   <= '0;
        r_acc_q <= '0;
      end else if (w_ws) begin
        r_c_q <= in_n;
        if (w_capture) r_b_q <= in_w;
      end else begin
        if (inst_w[INST_EXEC]) r_b_q <= in_n[bw-1:0];
        if (inst_w[INST_FLUSH])     r_acc_q <= in_n;
        else if (r_inst_q[INST_EXEC]) r_acc_q <= w_mac;
      end
    end
  end

  assign w_mac_c = w_ws ? r_c_q : r_acc_q;
  assign w_b_ext = {{(psum_bw-bw){r_b_q[bw-1]}}, r_b_q};

  mac #(.bw(bw), .psum_bw(psum_bw)) u_mac (
    .i_a   (r_a_q),
    .i_b   (r_b_q),
    .i_c   (w_mac_c),
    .o_out (w_mac)
  );

  // The arriving flush exposes the local sum before the north value overwrites it.
  assign out_s  = w_ws ? w_mac
                : ((r_inst_q[INST_FLUSH] || inst_w[INST_FLUSH]) ? r_acc_q : w_b_ext);
  assign out_e  = r_a_q;
  assign inst_e = r_inst_q;
endmodule
